// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers.
// Lane indices name the generic data words carried across the D/E boundary.
package pipe_stage_reg_pkg;

  localparam logic [4:0]  EXC_NONE         = 5'd0;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  localparam int LANE_RD1 = 0;
  localparam int LANE_RD2 = 1;
  localparam int LANE_EXT = 2;
  localparam int LANE_PC8 = 3;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: counts inc_i cycles, sticks at all-ones.
// Synchronous active-high reset clears it.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: registers take non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)                       cnt_q <= '0;
    else if (inc_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall hold, bubble insertion on flush,
// valid tracking and saturating stall/bubble performance counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int          DATA_W           = 32,
  parameter int          NUM_LANES        = 4,
  parameter logic [31:0] PC_RESET         = PC_RESET_DEFAULT,
  parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
  parameter int          CNT_W            = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic                        valid_i,
  input  logic [31:0]                 instr_i,
  input  logic [31:0]                 pc_i,
  input  logic                        bd_i,
  input  logic [4:0]                  exc_i,
  input  logic [NUM_LANES*DATA_W-1:0] data_i,
  output logic                        valid_o,
  output logic [31:0]                 instr_o,
  output logic [31:0]                 pc_o,
  output logic                        bd_o,
  output logic [4:0]                  exc_o,
  output logic [NUM_LANES*DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]            stall_cnt_o,
  output logic [CNT_W-1:0]            bubble_cnt_o
);

  logic                        valid_q, valid_d;
  logic [31:0]                 instr_q, instr_d;
  logic [31:0]                 pc_q,    pc_d;
  logic                        bd_q,    bd_d;
  logic [4:0]                  exc_q,   exc_d;
  logic [NUM_LANES*DATA_W-1:0] data_q,  data_d;

  // NOTE: hold is the default for every next-state signal, so no path infers a latch.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    data_d  = data_q;
    if (flush_i) begin
      // A bubble must never look like an exception source downstream.
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      exc_d   = EXC_NONE;
      data_d  = '0;
      pc_d    = KEEP_PC_ON_FLUSH ? pc_i : PC_RESET;
      bd_d    = KEEP_PC_ON_FLUSH ? bd_i : 1'b0;
    end else if (!stall_i) begin
      valid_d = valid_i;
      instr_d = instr_i;
      pc_d    = pc_i;
      bd_d    = bd_i;
      exc_d   = exc_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= PC_RESET;
      bd_q    <= 1'b0;
      exc_q   <= EXC_NONE;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
      data_q  <= data_d;
    end
  end

  logic stall_inc, bubble_inc;
  assign stall_inc  = !flush_i && stall_i;
  assign bubble_inc = flush_i || (!stall_i && !valid_i);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign bd_o    = bd_q;
  assign exc_o   = exc_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance driven from a vector
// table, plus KEEP_PC_ON_FLUSH=0 and CNT_W=3 instances for the corner sequences.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int DW = 4 * 32;

  logic          clk = 1'b0;
  logic          reset, stall_i, flush_i, valid_i, bd_i;
  logic [31:0]   instr_i, pc_i;
  logic [4:0]    exc_i;
  logic [DW-1:0] data_i;

  logic          a_valid, a_bd;
  logic [31:0]   a_instr, a_pc, a_scnt, a_bcnt;
  logic [4:0]    a_exc;
  logic [DW-1:0] a_data;

  logic          b_valid, b_bd;
  logic [31:0]   b_instr, b_pc, b_scnt, b_bcnt;
  logic [4:0]    b_exc;
  logic [DW-1:0] b_data;

  logic          c_valid, c_bd;
  logic [31:0]   c_instr, c_pc;
  logic [2:0]    c_scnt, c_bcnt;
  logic [4:0]    c_exc;
  logic [DW-1:0] c_data;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .instr_i(instr_i), .pc_i(pc_i), .bd_i(bd_i), .exc_i(exc_i), .data_i(data_i),
    .valid_o(a_valid), .instr_o(a_instr), .pc_o(a_pc), .bd_o(a_bd), .exc_o(a_exc),
    .data_o(a_data), .stall_cnt_o(a_scnt), .bubble_cnt_o(a_bcnt)
  );

  pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0)) u_dut_nokeep (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .instr_i(instr_i), .pc_i(pc_i), .bd_i(bd_i), .exc_i(exc_i), .data_i(data_i),
    .valid_o(b_valid), .instr_o(b_instr), .pc_o(b_pc), .bd_o(b_bd), .exc_o(b_exc),
    .data_o(b_data), .stall_cnt_o(b_scnt), .bubble_cnt_o(b_bcnt)
  );

  pipe_stage_reg #(.CNT_W(3)) u_dut_cnt3 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .instr_i(instr_i), .pc_i(pc_i), .bd_i(bd_i), .exc_i(exc_i), .data_i(data_i),
    .valid_o(c_valid), .instr_o(c_instr), .pc_o(c_pc), .bd_o(c_bd), .exc_o(c_exc),
    .data_o(c_data), .stall_cnt_o(c_scnt), .bubble_cnt_o(c_bcnt)
  );

  typedef struct {
    logic          rst, stall, flush, valid;
    logic [31:0]   instr, pc;
    logic          bd;
    logic [4:0]    exc;
    logic [DW-1:0] data;
    logic          e_valid;
    logic [31:0]   e_instr, e_pc;
    logic          e_bd;
    logic [4:0]    e_exc;
    logic [DW-1:0] e_data;
    logic [31:0]   e_scnt, e_bcnt;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] lane(int k, logic [31:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[k*32 +: 32] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic v,
                       input logic [31:0] ins, input logic [31:0] p, input logic b,
                       input logic [4:0] e, input logic [DW-1:0] d);
    reset = r; stall_i = s; flush_i = f; valid_i = v;
    instr_i = ins; pc_i = p; bd_i = b; exc_i = e; data_i = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] ones, bf;
    ones = '1;
    bf   = lane(LANE_EXT, 32'hDEAD_BEEF);

    // rst stall flush valid instr pc bd exc data | valid instr pc bd exc data scnt bcnt
    vecs[0]  = '{1,0,0,1, 32'h3C01_0001, 32'h3004, 0, 0, '0,
                 0, 32'h0, 32'h3000, 0, 0, '0, 0, 0};
    vecs[1]  = '{0,0,0,1, 32'h3C01_0001, 32'h3004, 0, 0, '0,
                 1, 32'h3C01_0001, 32'h3004, 0, 0, '0, 0, 0};
    vecs[2]  = '{0,0,0,1, 32'h8C22_0004, 32'h3008, 0, 0, bf,
                 1, 32'h8C22_0004, 32'h3008, 0, 0, bf, 0, 0};
    vecs[3]  = '{0,1,0,0, 32'h1111_1111, 32'h300C, 1, 3, ones,
                 1, 32'h8C22_0004, 32'h3008, 0, 0, bf, 1, 0};
    vecs[4]  = '{0,1,0,1, 32'h2222_2222, 32'h3010, 0, 7, lane(LANE_RD1, 32'h9),
                 1, 32'h8C22_0004, 32'h3008, 0, 0, bf, 2, 0};
    vecs[5]  = '{0,1,0,0, 32'h3333_3333, 32'h3014, 1, 1, ones,
                 1, 32'h8C22_0004, 32'h3008, 0, 0, bf, 3, 0};
    vecs[6]  = '{0,1,1,1, 32'h1234_5678, 32'h3010, 1, 4, ones,
                 0, 32'h0, 32'h3010, 1, 0, '0, 3, 1};
    vecs[7]  = '{0,0,0,0, 32'h0, 32'h3014, 0, 0, lane(LANE_RD1, 32'h5),
                 0, 32'h0, 32'h3014, 0, 0, lane(LANE_RD1, 32'h5), 3, 2};
    vecs[8]  = '{0,0,0,0, 32'hAABB_CCDD, 32'h3018, 0, 2, lane(LANE_RD2, 32'h7),
                 0, 32'hAABB_CCDD, 32'h3018, 0, 2, lane(LANE_RD2, 32'h7), 3, 3};
    vecs[9]  = '{0,0,0,1, 32'h0000_0020, 32'h301C, 1, 0, lane(LANE_PC8, 32'h3024),
                 1, 32'h0000_0020, 32'h301C, 1, 0, lane(LANE_PC8, 32'h3024), 3, 3};
    vecs[10] = '{1,1,1,1, 32'h5555_5555, 32'h4000, 1, 6, ones,
                 0, 32'h0, 32'h3000, 0, 0, '0, 0, 0};
    vecs[11] = '{0,1,0,1, 32'h6666_6666, 32'h4004, 1, 6, ones,
                 0, 32'h0, 32'h3000, 0, 0, '0, 1, 0};
    vecs[12] = '{0,0,0,1, 32'h0000_0001, 32'h3020, 0, 0, lane(LANE_RD2, 32'hA),
                 1, 32'h0000_0001, 32'h3020, 0, 0, lane(LANE_RD2, 32'hA), 1, 0};
    vecs[13] = '{0,0,1,1, 32'h7777_7777, 32'h3024, 0, 5, ones,
                 0, 32'h0, 32'h3024, 0, 0, '0, 1, 1};

    drive(1, 0, 0, 0, '0, '0, 0, '0, '0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].valid,
            vecs[i].instr, vecs[i].pc, vecs[i].bd, vecs[i].exc, vecs[i].data);
      step();
      check($sformatf("v%0d.valid", i), DW'(a_valid), DW'(vecs[i].e_valid));
      check($sformatf("v%0d.instr", i), DW'(a_instr), DW'(vecs[i].e_instr));
      check($sformatf("v%0d.pc", i),    DW'(a_pc),    DW'(vecs[i].e_pc));
      check($sformatf("v%0d.bd", i),    DW'(a_bd),    DW'(vecs[i].e_bd));
      check($sformatf("v%0d.exc", i),   DW'(a_exc),   DW'(vecs[i].e_exc));
      check($sformatf("v%0d.data", i),  a_data,       vecs[i].e_data);
      check($sformatf("v%0d.scnt", i),  DW'(a_scnt),  DW'(vecs[i].e_scnt));
      check($sformatf("v%0d.bcnt", i),  DW'(a_bcnt),  DW'(vecs[i].e_bcnt));
      @(negedge clk);
    end

    // Flush+stall with KEEP_PC_ON_FLUSH=0 versus =1.
    drive(1, 0, 0, 0, '0, '0, 0, '0, '0);
    step(); @(negedge clk);
    drive(0, 0, 0, 1, 32'h2001_0005, 32'h3004, 0, 0, lane(LANE_RD1, 32'h1));
    step(); @(negedge clk);
    drive(0, 1, 1, 1, 32'h2001_0006, 32'h3010, 1, 4, ones);
    step();
    check("nokeep.pc",    DW'(b_pc),    DW'(32'h3000));
    check("nokeep.bd",    DW'(b_bd),    DW'(1'b0));
    check("nokeep.valid", DW'(b_valid), DW'(1'b0));
    check("nokeep.instr", DW'(b_instr), DW'(32'h0));
    check("nokeep.exc",   DW'(b_exc),   DW'(5'd0));
    check("nokeep.data",  b_data,       DW'(0));
    check("nokeep.bcnt",  DW'(b_bcnt),  DW'(1));
    check("nokeep.scnt",  DW'(b_scnt),  DW'(0));
    check("keep.pc",      DW'(a_pc),    DW'(32'h3010));
    check("keep.bd",      DW'(a_bd),    DW'(1'b1));
    @(negedge clk);

    // Saturation with CNT_W=3: stall for 10 cycles, then flush for 10 cycles.
    drive(1, 0, 0, 1, '0, '0, 0, '0, '0);
    step(); @(negedge clk);
    check("cnt3.rst_s", DW'(c_scnt), DW'(0));
    for (int i = 1; i <= 10; i++) begin
      drive(0, 1, 0, 1, 32'h1, 32'h3000 + 32'(i), 0, 0, '0);
      step();
      check($sformatf("cnt3.stall%0d", i), DW'(c_scnt), DW'((i > 7) ? 7 : i));
      @(negedge clk);
    end
    check("cnt3.bcnt_idle", DW'(c_bcnt), DW'(0));
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 1, 32'h1, 32'h3100, 0, 0, '0);
      step();
      check($sformatf("cnt3.bub%0d", i), DW'(c_bcnt), DW'((i > 7) ? 7 : i));
      @(negedge clk);
    end
    check("cnt3.scnt_hold", DW'(c_scnt), DW'(7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
